// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch stage owning the PC and IF/ID register; single
//               outstanding imem request, redirect drain, stall buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_sel,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_BUF   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_redirect;
  logic [31:0] w_sel_target;
  logic [31:0] w_target;
  logic [2:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_buf_load;
  logic        w_deliver;
  logic [31:0] w_deliver_instr;

  assign w_redirect   = jump | branch_sel;
  assign w_sel_target = jump ? jump_target : branch_target;
  assign w_target     = w_sel_target & ~32'd3;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_buf_load      = 1'b0;
    w_deliver       = 1'b0;
    w_deliver_instr = imem_rdata;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redirect) w_pc_nxt = w_target;
      end
      S_REQ: begin
        // Address only moves without a grant when a redirect arrives.
        if (imem_gnt) w_state_nxt = w_redirect ? S_DRAIN : S_RESP;
        if (w_redirect) w_pc_nxt = w_target;
      end
      S_RESP: begin
        if (imem_rvalid) begin
          if (w_redirect) begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = w_target;
          end else if (stall) begin
            w_state_nxt = S_BUF;
            w_buf_load  = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
            w_deliver   = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
          end
        end else if (w_redirect) begin
          w_state_nxt = S_DRAIN;
          w_pc_nxt    = w_target;
        end
      end
      S_BUF: begin
        if (w_redirect) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = w_target;
        end else if (!stall) begin
          w_state_nxt     = S_REQ;
          w_deliver       = 1'b1;
          w_deliver_instr = r_buf;
          w_pc_nxt        = r_pc + 32'd4;
        end
      end
      S_DRAIN: begin
        // The stale response is swallowed; pc already points at the target.
        if (w_redirect) w_pc_nxt = w_target;
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_buf_load) r_buf <= imem_rdata;
    end
  end

  // Flush beats stall; a non-stalled cycle without delivery inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'd0;
      r_if_instr <= NOP_INSTR;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (w_deliver) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_instr <= w_deliver_instr;
      end else begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign if_id_valid = r_if_valid;
  assign if_id_pc    = r_if_pc;
  assign if_id_instr = r_if_instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Bench for fetch_pc_ctrl: transaction-level reference model,
//               directed scenarios with literal expectations, random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_sel = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  fetch_pc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_sel   (branch_sel),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // memory knobs and state
  int          gnt_pct = 100;
  int          lat_lo = 0;
  int          lat_hi = 0;
  bit          rd_fixed_en = 1'b1;
  logic [31:0] rd_fixed = 32'h0000_0093;
  bit          pend = 1'b0;
  int          cnt = 0;

  // reference model: fetch phase flags rather than an encoded state
  bit          m_first, m_asking, m_waiting, m_discard, m_holding;
  logic [31:0] m_pc, m_hold;
  bit          m_v;
  logic [31:0] m_ipc, m_iinstr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_first = 1; m_asking = 0; m_waiting = 0; m_discard = 0; m_holding = 0;
    m_pc = 32'd0; m_hold = 32'd0;
    m_v = 0; m_ipc = 32'd0; m_iinstr = NOP;
    pend = 0; cnt = 0;
  endtask

  task automatic model_step();
    bit          redir, got;
    logic [31:0] tgt, gpc, ginstr;
    redir  = jump | branch_sel;
    tgt    = jump ? jump_target : branch_target;
    tgt    = {tgt[31:2], 2'b00};
    got    = 0;
    gpc    = m_pc;
    ginstr = 32'd0;
    if (m_first) begin
      m_first = 0; m_asking = 1;
      if (redir) m_pc = tgt;
    end else if (m_asking) begin
      if (imem_gnt) begin m_asking = 0; m_waiting = 1; m_discard = redir; end
      if (redir) m_pc = tgt;
    end else if (m_waiting) begin
      if (imem_rvalid) begin
        m_waiting = 0;
        m_asking  = 1;
        if (m_discard || redir) begin
          m_discard = 0;
          if (redir) m_pc = tgt;
        end else if (stall) begin
          m_asking = 0; m_holding = 1; m_hold = imem_rdata;
        end else begin
          got = 1; ginstr = imem_rdata; m_pc = m_pc + 32'd4;
        end
      end else if (redir) begin
        m_discard = 1; m_pc = tgt;
      end
    end else if (m_holding) begin
      if (redir) begin
        m_holding = 0; m_asking = 1; m_pc = tgt;
      end else if (!stall) begin
        got = 1; ginstr = m_hold; m_pc = m_pc + 32'd4;
        m_holding = 0; m_asking = 1;
      end
    end
    if (redir) begin
      m_v = 0; m_iinstr = NOP;
    end else if (!stall) begin
      if (got) begin m_v = 1; m_ipc = gpc; m_iinstr = ginstr; end
      else begin m_v = 0; m_iinstr = NOP; end
    end
  endtask

  // One clock: memory drives, model advances, then outputs compared mid-cycle.
  task automatic step();
    imem_rvalid = 0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata  = rd_fixed_en ? rd_fixed : $urandom;
        pend = 0;
      end else cnt--;
    end
    imem_gnt = imem_req && !pend && !imem_rvalid && ($urandom_range(99) < gnt_pct);
    if (imem_gnt) begin
      pend = 1;
      cnt  = $urandom_range(lat_hi, lat_lo);
    end
    model_step();
    @(negedge clk);
    chk("cyc_req",    {31'd0, imem_req},    {31'd0, m_asking});
    chk("cyc_addr",   imem_addr,            m_pc);
    chk("cyc_valid",  {31'd0, if_id_valid}, {31'd0, m_v});
    chk("cyc_pc",     if_id_pc,             m_ipc);
    chk("cyc_instr",  if_id_instr,          m_iinstr);
  endtask

  task automatic clr_redirect();
    branch_sel = 0; jump = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc",    if_id_pc,             32'd0);
    chk("rst_instr", if_id_instr,          NOP);
    rst_n = 1;

    // basic fetch: 1-cycle grant and response
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    step();
    chk("resp_noreq", {31'd0, imem_req}, 32'd0);
    step();
    chk("f0_addr4", imem_addr, 32'd4);
    chk("f0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("f0_pc", if_id_pc, 32'd0);
    chk("f0_instr", if_id_instr, 32'h0000_0093);
    step(); step();
    chk("f1_addr8", imem_addr, 32'd8);

    // stall while the response arrives
    step();
    stall = 1;
    rd_fixed = 32'hCAFE_0001;
    step();
    step();
    step();
    chk("buf_noreq", {31'd0, imem_req}, 32'd0);
    chk("buf_valid", {31'd0, if_id_valid}, 32'd0);
    stall = 0;
    step();
    chk("buf_rel_pc", if_id_pc, 32'd8);
    chk("buf_rel_instr", if_id_instr, 32'hCAFE_0001);
    chk("buf_rel_addr", imem_addr, 32'd12);

    // branch during RESP, late response drained
    lat_lo = 3; lat_hi = 3;
    step();
    branch_sel = 1; branch_target = 32'h100;
    step();
    clr_redirect();
    chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
    begin
      int k;
      for (k = 0; k < 10 && !imem_req; k++) step();
      chk("drain_bound", {31'd0, imem_req}, 32'd1);
    end
    chk("drain_addr", imem_addr, 32'h100);
    chk("drain_nodeliver", {31'd0, if_id_valid}, 32'd0);

    // jump beats branch, flush beats stall
    lat_lo = 0; lat_hi = 0;
    step(); step();
    chk("pre_jump_valid", {31'd0, if_id_valid}, 32'd1);
    gnt_pct = 0;
    stall = 1; jump = 1; jump_target = 32'h200; branch_sel = 1; branch_target = 32'h300;
    step();
    clr_redirect(); stall = 0;
    chk("jmp_addr", imem_addr, 32'h200);
    chk("jmp_req", {31'd0, imem_req}, 32'd1);
    chk("jmp_flush", {31'd0, if_id_valid}, 32'd0);
    chk("jmp_pc_kept", if_id_pc, 32'h100);

    // unaligned redirect without grant
    branch_sel = 1; branch_target = 32'h103;
    step();
    clr_redirect();
    chk("align_addr", imem_addr, 32'h100);
    chk("align_req", {31'd0, imem_req}, 32'd1);

    // PC wrap
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step();
    clr_redirect();
    gnt_pct = 100;
    step(); step();
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);

    // async reset mid-RESP
    lat_lo = 3; lat_hi = 3;
    step();
    #2 rst_n = 0;
    #1;
    chk("arst_req",   {31'd0, imem_req},    32'd0);
    chk("arst_addr",  imem_addr,            32'd0);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst_pc",    if_id_pc,             32'd0);
    chk("arst_instr", if_id_instr,          NOP);
    model_reset();
    imem_gnt = 0; imem_rvalid = 0;
    @(negedge clk);
    rst_n = 1;

    // random traffic
    rd_fixed_en = 0;
    for (int i = 0; i < 3000; i++) begin
      gnt_pct = (i % 500 < 250) ? 70 : 100;
      lat_lo = 0;
      lat_hi = (i % 300 < 150) ? 0 : 4;
      stall = ($urandom_range(2) == 0);
      branch_sel = ($urandom_range(9) == 0);
      jump = ($urandom_range(11) == 0);
      branch_target = $urandom;
      jump_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Instruction-fetch stage that owns the program counter and the IF/ID pipeline register; it consumes the taken-branch decision (`branch_sel`) and jump request produced in EX and redirects fetch accordingly. It talks to instruction memory over a request/grant/response handshake with one outstanding request. It discards in-flight responses after a redirect and buffers a returned instruction while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset
- `NOP_INSTR`, 32'h0000_0013, instruction driven in IF/ID when invalid (addi x0,x0,0)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `branch_sel` input 1: taken conditional branch from EX, valid this cycle
- `branch_target` input 32: target for `branch_sel`
- `jump` input 1: JAL/JALR redirect from EX
- `jump_target` input 32: target for `jump`
- `stall` input 1: decode stall; IF/ID must hold
- `imem_req` output 1: fetch request
- `imem_addr` output 32: fetch address, word-aligned
- `imem_gnt` input 1: request accepted this cycle
- `imem_rvalid` input 1: response valid
- `imem_rdata` input 32: instruction, qualified by `imem_rvalid`
- `if_id_valid` output 1: IF/ID holds a real instruction
- `if_id_pc` output 32: PC of IF/ID instruction
- `if_id_instr` output 32: IF/ID instruction

## Operation
- `redirect = jump | branch_sel`; `target = jump ? jump_target : branch_target` (jump wins if both); `target[1:0]` forced to 00.
- Registered `pc` = address of the instruction currently being fetched; `imem_addr = pc`.
- States: IDLE, REQ, RESP, BUF, DRAIN.
- IDLE: `imem_req=0`; always → REQ next cycle (redirect in IDLE: `pc<=target`).
- REQ: `imem_req=1`. `gnt & !redirect` → RESP. `gnt & redirect` → DRAIN, `pc<=target`. `!gnt & redirect` → stay REQ, `pc<=target` (address may change without grant only on redirect). Otherwise hold address and stay.
- RESP: `imem_req=0`. `rvalid & redirect` → discard, REQ, `pc<=target`. `rvalid & !stall` → IF/ID <= {1, pc, rdata}, `pc<=pc+4`, REQ. `rvalid & stall` → latch rdata in buffer, BUF. `!rvalid & redirect` → DRAIN, `pc<=target`.
- BUF: `imem_req=0`. redirect → drop buffer, REQ, `pc<=target`. `!stall` → IF/ID <= {1, pc, buf}, `pc<=pc+4`, REQ.
- DRAIN: `imem_req=0`; wait for `rvalid`, discard data, → REQ (a redirect in DRAIN only updates `pc`).
- IF/ID update, priority order: redirect → `if_id_valid<=0`, `if_id_instr<=NOP_INSTR`, `if_id_pc` unchanged (flush overrides stall). Else stall → hold. Else, if no instruction is delivered this cycle → `if_id_valid<=0`, instr NOP (bubble).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (async assert, sync-safe release): state IDLE, `pc=RESET_PC`, `imem_req=0`, `imem_addr=RESET_PC`, `if_id_valid=0`, `if_id_pc=0`, `if_id_instr=NOP_INSTR`, buffer cleared.
- First request cycle: 1 cycle after reset release.
- Best-case throughput: one instruction per 2 cycles (REQ with grant, RESP with rvalid the following cycle).
- Latency: `rvalid` in cycle N → `if_id_valid=1` in N+1 if not stalled.
- Redirect in cycle N → IF/ID flushed in N+1; first request to the target is visible in N+1 (from REQ/RESP-with-rvalid/BUF) or after the drain response arrives (from DRAIN).
- Reset mid-transaction: the outstanding response is not tracked; memory must be reset with the same `rst_n`.

## Test plan
- Reset, 1-cycle grant, 1-cycle response, rdata=32'h0000_0093 → `imem_addr` 0,4,8 on successive REQ cycles; `if_id_pc`=0 with instr 0x93 two cycles after first grant.
- `stall=1` for 3 cycles when `rvalid` arrives → BUF held; IF/ID unchanged; on release, instr written and `pc+=4`; no request issued while in BUF.
- `branch_sel=1`, target 0x100, while in RESP without rvalid → DRAIN; late response (3 cycles) discarded; next `imem_addr`=0x100; `if_id_valid=0`.
- `jump=1` (0x200) and `branch_sel=1` (0x300) same cycle with `stall=1` → target 0x200, IF/ID flushed despite stall.
- Redirect to 0x103 in REQ without grant → `imem_addr`=0x100 next cycle with `imem_req` still high.
- `pc`=32'hFFFF_FFFC fetch completes → next `imem_addr`=0; async `rst_n` low mid-RESP → all outputs at reset values immediately.
